// File: rtl/pool_line_buffer.sv
// -----------------------------------------------------------------------------
// pool_line_buffer
//
// Regroups a raster-ordered pixel stream into non-overlapping 2x2 windows for a
// downstream pooling stage. Even rows are parked in a one-row line buffer. On
// odd rows, each even-column pixel is held and the matching pair of line-buffer
// entries is prefetched. The odd-column pixel then completes the window, which
// is presented one cycle later.
//
// Ports
//   plb_clk       in   1                          clock, rising edge
//   plb_rst_b     in   1                          synchronous active-low reset
//   pix_i         in   OPERAND_WDTH               pixel, raster order
//   pix_vld_i     in   1                          pix_i valid (gaps allowed)
//   sof_i         in   1                          start of frame (with pix_vld_i)
//   plb_a_o       out  [NUM_PIXELS][OPERAND_WDTH] top window row    ([0]=even col)
//   plb_b_o       out  [NUM_PIXELS][OPERAND_WDTH] bottom window row ([0]=even col)
//   win_vld_o     out  1                          one-cycle new-window pulse
//   frame_done_o  out  1                          last window of the frame
// -----------------------------------------------------------------------------
module pool_line_buffer #(
    parameter int OPERAND_WDTH = 19,
    parameter int NUM_PIXELS   = 2,
    parameter int IMG_WDTH     = 28,
    parameter int IMG_HGHT     = 28
) (
    input  logic                                    plb_clk,
    input  logic                                    plb_rst_b,
    input  logic [OPERAND_WDTH-1:0]                 pix_i,
    input  logic                                    pix_vld_i,
    input  logic                                    sof_i,
    output logic [NUM_PIXELS-1:0][OPERAND_WDTH-1:0] plb_a_o,
    output logic [NUM_PIXELS-1:0][OPERAND_WDTH-1:0] plb_b_o,
    output logic                                    win_vld_o,
    output logic                                    frame_done_o
);

    localparam int COL_W = (IMG_WDTH > 1) ? $clog2(IMG_WDTH) : 1;
    localparam int ROW_W = (IMG_HGHT > 1) ? $clog2(IMG_HGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HGHT - 1);

    // Position counters (point at the next expected pixel)
    logic [COL_W-1:0] col_reg;
    logic [COL_W-1:0] col_next;
    logic [ROW_W-1:0] row_reg;
    logic [ROW_W-1:0] row_next;

    // Position of the pixel currently on pix_i; sof_i forces it to (0,0)
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             col_last;
    logic             row_last;

    // Per-pixel actions
    logic             line_wr;
    logic             pair_ld;
    logic             win_next;
    logic             done_next;

    // Storage
    logic [OPERAND_WDTH-1:0] line_mem [IMG_WDTH];
    logic [OPERAND_WDTH-1:0] hold_reg;
    logic [OPERAND_WDTH-1:0] top_lo_reg;
    logic [OPERAND_WDTH-1:0] top_hi_reg;
    logic [COL_W-1:0]        pair_hi_col;

    always_comb begin
        cur_col   = sof_i ? '0 : col_reg;
        cur_row   = sof_i ? '0 : row_reg;
        col_last  = (cur_col == COL_LAST);
        row_last  = (cur_row == ROW_LAST);

        col_next  = col_reg;
        row_next  = row_reg;
        if (pix_vld_i) begin
            if (col_last) begin
                col_next = '0;
                row_next = row_last ? '0 : ROW_W'(cur_row + 1'b1);
            end else begin
                col_next = COL_W'(cur_col + 1'b1);
                row_next = cur_row;
            end
        end

        line_wr     = pix_vld_i && !cur_row[0];
        pair_ld     = pix_vld_i &&  cur_row[0] && !cur_col[0];
        win_next    = pix_vld_i &&  cur_row[0] &&  cur_col[0];
        done_next   = win_next && row_last && col_last;
        pair_hi_col = COL_W'(cur_col + 1'b1);
    end

    // Line buffer: no reset needed, every entry is rewritten on each even row
    // before the following odd row reads it.
    always_ff @(posedge plb_clk) begin
        if (plb_rst_b && line_wr) begin
            line_mem[cur_col] <= pix_i;
        end
    end

    // Registered read: both top-row entries of the window are fetched when the
    // even-column pixel of the odd row arrives, so they are ready however many
    // idle cycles separate it from the odd-column pixel.
    always_ff @(posedge plb_clk) begin
        if (!plb_rst_b) begin
            col_reg    <= '0;
            row_reg    <= '0;
            hold_reg   <= '0;
            top_lo_reg <= '0;
            top_hi_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
            if (pair_ld) begin
                hold_reg   <= pix_i;
                top_lo_reg <= line_mem[cur_col];
                top_hi_reg <= line_mem[pair_hi_col];
            end
        end
    end

    // Window outputs hold their value until the next window completes.
    always_ff @(posedge plb_clk) begin
        if (!plb_rst_b) begin
            plb_a_o      <= '0;
            plb_b_o      <= '0;
            win_vld_o    <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            win_vld_o    <= win_next;
            frame_done_o <= done_next;
            if (win_next) begin
                plb_a_o[0] <= top_lo_reg;
                plb_a_o[1] <= top_hi_reg;
                plb_b_o[0] <= hold_reg;
                plb_b_o[1] <= pix_i;
            end
        end
    end

endmodule

// File: tb/tb_pool_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_pool_line_buffer
//
// Directed bench for pool_line_buffer. A 4x4 instance covers raster, gapped,
// resync and mid-frame reset scenarios; a default 28x28 instance covers the
// full-size checkerboard frame. Expected windows are derived from pixel
// position: pixel p at (r,c) with r,c odd closes the window whose top-left
// pixel is p-IMG_WDTH-1.
// -----------------------------------------------------------------------------
module tb_pool_line_buffer;

    localparam int W = 19;

    logic clk;
    logic rst_b;

    // 4x4 instance
    logic [W-1:0]        pix4;
    logic                vld4;
    logic                sof4;
    logic [1:0][W-1:0]   a4;
    logic [1:0][W-1:0]   b4;
    logic                win4;
    logic                fd4;

    // 28x28 instance
    logic [W-1:0]        pix28;
    logic                vld28;
    logic                sof28;
    logic [1:0][W-1:0]   a28;
    logic [1:0][W-1:0]   b28;
    logic                win28;
    logic                fd28;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0][W-1:0] exp_a;
    logic [1:0][W-1:0] exp_b;
    logic              exp_w;

    pool_line_buffer #(
        .OPERAND_WDTH(W), .NUM_PIXELS(2), .IMG_WDTH(4), .IMG_HGHT(4)
    ) dut4 (
        .plb_clk(clk), .plb_rst_b(rst_b), .pix_i(pix4), .pix_vld_i(vld4),
        .sof_i(sof4), .plb_a_o(a4), .plb_b_o(b4), .win_vld_o(win4),
        .frame_done_o(fd4)
    );

    pool_line_buffer dut28 (
        .plb_clk(clk), .plb_rst_b(rst_b), .pix_i(pix28), .pix_vld_i(vld28),
        .sof_i(sof28), .plb_a_o(a28), .plb_b_o(b28), .win_vld_o(win28),
        .frame_done_o(fd28)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input cycle to the 4x4 instance, then sample 1 ns after the edge.
    task automatic drive4(input logic [W-1:0] v, input logic vld, input logic sof);
        pix4 = v;
        vld4 = vld;
        sof4 = sof;
        @(posedge clk);
        #1;
    endtask

    task automatic drive28(input logic [W-1:0] v, input logic vld, input logic sof);
        pix28 = v;
        vld28 = vld;
        sof28 = sof;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        drive4(19'd55, 1'b1, 1'b1);
        drive4(19'd56, 1'b1, 1'b0);
        n_checks++;
        if (a4 !== '0 || b4 !== '0) begin
            n_fail++;
            $display("FAIL reset_data4 a=%h b=%h required 0", a4, b4);
        end
        n_checks++;
        if (win4 !== 1'b0 || fd4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags4 win=%b fd=%b required 0", win4, fd4);
        end
        n_checks++;
        if (a28 !== '0 || b28 !== '0 || win28 !== 1'b0 || fd28 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_28 a=%h b=%h win=%b fd=%b required 0", a28, b28, win28, fd28);
        end
        $display("reset: a4=%h b4=%h win4=%b fd4=%b", a4, b4, win4, fd4);
        rst_b = 1'b1;
        drive4('0, 1'b0, 1'b0);
    endtask

    task automatic test_raster();
        int nwin = 0;
        for (int p = 0; p < 16; p++) begin
            drive4(19'(p), 1'b1, p == 0);
            exp_w = ((p / 4) % 2 == 1) && ((p % 4) % 2 == 1);
            n_checks++;
            if (win4 !== exp_w) begin
                n_fail++;
                $display("FAIL raster_vld pix=%0d got %b required %b", p, win4, exp_w);
            end
            n_checks++;
            if (fd4 !== (p == 15)) begin
                n_fail++;
                $display("FAIL raster_done pix=%0d got %b required %b", p, fd4, p == 15);
            end
            if (exp_w) begin
                nwin++;
                exp_a[0] = 19'(p - 5); exp_a[1] = 19'(p - 4);
                exp_b[0] = 19'(p - 1); exp_b[1] = 19'(p);
                n_checks++;
                if (a4 !== exp_a || b4 !== exp_b) begin
                    n_fail++;
                    $display("FAIL raster_win pix=%0d got a=%h b=%h required a=%h b=%h",
                             p, a4, b4, exp_a, exp_b);
                end
                $display("raster: window %0d a={%0d,%0d} b={%0d,%0d} fd=%b",
                         nwin, a4[0], a4[1], b4[0], b4[1], fd4);
            end
        end
        drive4('0, 1'b0, 1'b0);
        n_checks++;
        if (win4 !== 1'b0 || nwin != 4) begin
            n_fail++;
            $display("FAIL raster_count got %0d windows (trailing vld %b) required 4", nwin, win4);
        end
    endtask

    task automatic test_gapped();
        int nwin = 0;
        for (int p = 0; p < 16; p++) begin
            drive4(19'(p), 1'b1, p == 0);
            exp_w = ((p / 4) % 2 == 1) && ((p % 4) % 2 == 1);
            n_checks++;
            if (win4 !== exp_w || fd4 !== (p == 15)) begin
                n_fail++;
                $display("FAIL gapped_vld pix=%0d got win=%b fd=%b required win=%b fd=%b",
                         p, win4, fd4, exp_w, p == 15);
            end
            if (exp_w) begin
                nwin++;
                exp_a[0] = 19'(p - 5); exp_a[1] = 19'(p - 4);
                exp_b[0] = 19'(p - 1); exp_b[1] = 19'(p);
                n_checks++;
                if (a4 !== exp_a || b4 !== exp_b) begin
                    n_fail++;
                    $display("FAIL gapped_win pix=%0d got a=%h b=%h required a=%h b=%h",
                             p, a4, b4, exp_a, exp_b);
                end
                $display("gapped: window %0d a={%0d,%0d} b={%0d,%0d} fd=%b",
                         nwin, a4[0], a4[1], b4[0], b4[1], fd4);
            end
            // idle cycle: no pulse, window data held
            drive4(19'h1234, 1'b0, 1'b0);
            n_checks++;
            if (win4 !== 1'b0 || fd4 !== 1'b0) begin
                n_fail++;
                $display("FAIL gapped_idle after pix=%0d got win=%b fd=%b required 0", p, win4, fd4);
            end
            if (nwin > 0) begin
                n_checks++;
                if (a4 !== exp_a || b4 !== exp_b) begin
                    n_fail++;
                    $display("FAIL gapped_hold after pix=%0d got a=%h b=%h required a=%h b=%h",
                             p, a4, b4, exp_a, exp_b);
                end
            end
        end
        n_checks++;
        if (nwin != 4) begin
            n_fail++;
            $display("FAIL gapped_count got %0d required 4", nwin);
        end
    endtask

    task automatic test_resync();
        int nwin = 0;
        // Partial frame with distinct values 100..106. Pixel 5 closes a window
        // before the resync, so that one is still due; pixel 6 leaves a stale
        // hold value that the new frame must not use.
        for (int p = 0; p < 7; p++) begin
            drive4(19'(100 + p), 1'b1, p == 0);
            exp_w = (p == 5);
            n_checks++;
            if (win4 !== exp_w || fd4 !== 1'b0) begin
                n_fail++;
                $display("FAIL resync_partial pix=%0d got win=%b fd=%b required win=%b fd=0",
                         p, win4, fd4, exp_w);
            end
        end
        for (int p = 0; p < 16; p++) begin
            drive4(19'(p), 1'b1, p == 0);
            exp_w = ((p / 4) % 2 == 1) && ((p % 4) % 2 == 1);
            n_checks++;
            if (win4 !== exp_w || fd4 !== (p == 15)) begin
                n_fail++;
                $display("FAIL resync_vld pix=%0d got win=%b fd=%b required win=%b fd=%b",
                         p, win4, fd4, exp_w, p == 15);
            end
            if (exp_w) begin
                nwin++;
                exp_a[0] = 19'(p - 5); exp_a[1] = 19'(p - 4);
                exp_b[0] = 19'(p - 1); exp_b[1] = 19'(p);
                n_checks++;
                if (a4 !== exp_a || b4 !== exp_b) begin
                    n_fail++;
                    $display("FAIL resync_win pix=%0d got a=%h b=%h required a=%h b=%h",
                             p, a4, b4, exp_a, exp_b);
                end
                $display("resync: window %0d a={%0d,%0d} b={%0d,%0d} fd=%b",
                         nwin, a4[0], a4[1], b4[0], b4[1], fd4);
            end
        end
        drive4('0, 1'b0, 1'b0);
        n_checks++;
        if (nwin != 4) begin
            n_fail++;
            $display("FAIL resync_count got %0d required 4", nwin);
        end
    endtask

    task automatic test_midreset();
        int nwin = 0;
        for (int p = 0; p < 10; p++) begin
            drive4(19'(200 + p), 1'b1, p == 0);
        end
        // One reset cycle with a pixel presented; that pixel must be ignored.
        rst_b = 1'b0;
        drive4(19'd77, 1'b1, 1'b0);
        rst_b = 1'b1;
        n_checks++;
        if (a4 !== '0 || b4 !== '0 || win4 !== 1'b0 || fd4 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear got a=%h b=%h win=%b fd=%b required 0", a4, b4, win4, fd4);
        end
        $display("midreset: outputs after reset a=%h b=%h", a4, b4);
        // No sof: the first accepted pixel after reset is (0,0).
        for (int p = 0; p < 16; p++) begin
            drive4(19'(p), 1'b1, 1'b0);
            exp_w = ((p / 4) % 2 == 1) && ((p % 4) % 2 == 1);
            n_checks++;
            if (win4 !== exp_w || fd4 !== (p == 15)) begin
                n_fail++;
                $display("FAIL midreset_vld pix=%0d got win=%b fd=%b required win=%b fd=%b",
                         p, win4, fd4, exp_w, p == 15);
            end
            if (exp_w) begin
                nwin++;
                exp_a[0] = 19'(p - 5); exp_a[1] = 19'(p - 4);
                exp_b[0] = 19'(p - 1); exp_b[1] = 19'(p);
                n_checks++;
                if (a4 !== exp_a || b4 !== exp_b) begin
                    n_fail++;
                    $display("FAIL midreset_win pix=%0d got a=%h b=%h required a=%h b=%h",
                             p, a4, b4, exp_a, exp_b);
                end
                $display("midreset: window %0d a={%0d,%0d} b={%0d,%0d} fd=%b",
                         nwin, a4[0], a4[1], b4[0], b4[1], fd4);
            end
        end
        drive4('0, 1'b0, 1'b0);
        n_checks++;
        if (nwin != 4) begin
            n_fail++;
            $display("FAIL midreset_count got %0d required 4", nwin);
        end
    endtask

    task automatic test_checkerboard();
        int nwin  = 0;
        int ndone = 0;
        logic [W-1:0] v;
        for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) begin
                v = ((r + c) % 2 == 1) ? 19'h7FFFF : 19'h00000;
                drive28(v, 1'b1, (r == 0) && (c == 0));
                exp_w = (r % 2 == 1) && (c % 2 == 1);
                n_checks++;
                if (win28 !== exp_w) begin
                    n_fail++;
                    $display("FAIL cb_vld r=%0d c=%0d got %b required %b", r, c, win28, exp_w);
                end
                if (fd28 === 1'b1) ndone++;
                if (exp_w) begin
                    nwin++;
                    // r,c odd: top-left (r-1,c-1) has even parity sum -> zeros
                    // on the diagonal, ones on the anti-diagonal.
                    exp_a[0] = 19'h00000; exp_a[1] = 19'h7FFFF;
                    exp_b[0] = 19'h7FFFF; exp_b[1] = 19'h00000;
                    n_checks++;
                    if (a28 !== exp_a || b28 !== exp_b) begin
                        n_fail++;
                        $display("FAIL cb_win r=%0d c=%0d got a=%h b=%h required a=%h b=%h",
                                 r, c, a28, b28, exp_a, exp_b);
                    end
                    n_checks++;
                    if (fd28 !== (nwin == 196)) begin
                        n_fail++;
                        $display("FAIL cb_done window=%0d got %b required %b", nwin, fd28, nwin == 196);
                    end
                    $display("checkerboard: window %0d a=%h b=%h fd=%b", nwin, a28, b28, fd28);
                end
            end
        end
        drive28('0, 1'b0, 1'b0);
        n_checks++;
        if (nwin != 196 || ndone != 1 || win28 !== 1'b0) begin
            n_fail++;
            $display("FAIL cb_count got windows=%0d done=%0d required windows=196 done=1", nwin, ndone);
        end
    endtask

    initial begin
        rst_b = 1'b0;
        pix4  = '0; vld4  = 1'b0; sof4  = 1'b0;
        pix28 = '0; vld28 = 1'b0; sof28 = 1'b0;
        #1;
        test_reset();
        test_raster();
        test_gapped();
        test_resync();
        test_midreset();
        test_checkerboard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
